// File: rtl/usb_tx.sv
// USB full-speed packet serializer: SYNC, NRZI data with bit stuffing, EOP.
// Bytes arrive on a valid/ready stream. Each line symbol is held for
// CLOCKS_PER_BIT clocks. All line outputs are registered.
//
// Handshake: tx_data/tx_last are consumed in any cycle where tx_valid and
// tx_ready are both 1. tx_ready is asserted only in the cycle that ends the
// final bit period of SYNC or of a non-final byte, and only when tx_valid=1.
// If tx_valid=0 in that cycle, tx_underflow pulses instead and the packet is
// aborted with an EOP.
module usb_tx #(
    parameter int CLOCKS_PER_BIT = 4
) (
    input  logic       clock48,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       usb_dp,
    output logic       usb_dn,
    output logic       usb_oe,
    output logic       tx_done,
    output logic       tx_underflow,
    output logic [2:0] state_dbg
);

    localparam int DW = (CLOCKS_PER_BIT > 2) ? $clog2(CLOCKS_PER_BIT) : 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SYNC    = 3'd1,
        DATA    = 3'd2,
        EOP_SE0 = 3'd3,
        EOP_J   = 3'd4
    } state_t;

    state_t         state;
    logic [DW-1:0]  div;
    logic [2:0]     sync_cnt;
    logic [7:0]     shreg;      // bits of the current byte not yet sent, LSB next
    logic [3:0]     cnt;        // number of bits left in shreg
    logic           cur_last;   // current byte was flagged as the last one
    logic           in_stuff;   // symbol on the line is a stuffed bit
    logic [2:0]     ones;       // run length of consecutive data ones
    logic           eop_cnt;

    logic tick;
    logic load_due;
    logic next_bit;

    // Symbol boundary, byte-load request and the next data bit to send
    always_comb begin
        tick     = (div == DW'(CLOCKS_PER_BIT - 1));
        load_due = tick && (state == DATA) && (cnt == 4'd0) && !in_stuff && !cur_last;
        next_bit = (cnt != 4'd0) ? shreg[0] : tx_data[0];
    end

    assign tx_ready     = load_due && tx_valid;
    assign tx_underflow = load_due && !tx_valid;
    assign state_dbg    = state;

    // Packet sequencer; every line change happens on a divider wrap
    always_ff @(posedge clock48 or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            div      <= '0;
            sync_cnt <= '0;
            shreg    <= '0;
            cnt      <= '0;
            cur_last <= 1'b0;
            in_stuff <= 1'b0;
            ones     <= '0;
            eop_cnt  <= 1'b0;
            usb_oe   <= 1'b0;
            usb_dp   <= 1'b1;
            usb_dn   <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (state == IDLE) div <= '0;
            else               div <= tick ? '0 : div + DW'(1);

            case (state)
                IDLE: begin
                    if (tx_valid) begin
                        // Preload the divider so the first SYNC bit appears next edge
                        state    <= SYNC;
                        div      <= DW'(CLOCKS_PER_BIT - 1);
                        sync_cnt <= '0;
                    end
                end
                SYNC: begin
                    if (tick) begin
                        usb_oe   <= 1'b1;
                        usb_dp   <= sync_cnt[0] && (sync_cnt != 3'd7);
                        usb_dn   <= !(sync_cnt[0] && (sync_cnt != 3'd7));
                        sync_cnt <= sync_cnt + 3'd1;
                        if (sync_cnt == 3'd7) begin
                            // The trailing SYNC K counts as the first NRZI one
                            state    <= DATA;
                            cnt      <= '0;
                            cur_last <= 1'b0;
                            in_stuff <= 1'b0;
                            ones     <= 3'd1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (load_due && !tx_valid) begin
                            usb_dp  <= 1'b0;
                            usb_dn  <= 1'b0;
                            eop_cnt <= 1'b0;
                            state   <= EOP_SE0;
                        end else if (ones == 3'd6) begin
                            // Stuffed zero: toggle without consuming a data bit
                            usb_dp   <= ~usb_dp;
                            usb_dn   <= ~usb_dn;
                            ones     <= '0;
                            in_stuff <= 1'b1;
                            if (load_due) begin
                                shreg    <= tx_data;
                                cnt      <= 4'd8;
                                cur_last <= tx_last;
                            end
                        end else if ((cnt != 4'd0) || load_due) begin
                            if (!next_bit) begin
                                usb_dp <= ~usb_dp;
                                usb_dn <= ~usb_dn;
                            end
                            ones     <= next_bit ? ones + 3'd1 : 3'd0;
                            in_stuff <= 1'b0;
                            if (cnt != 4'd0) begin
                                shreg <= shreg >> 1;
                                cnt   <= cnt - 4'd1;
                            end else begin
                                shreg    <= tx_data >> 1;
                                cnt      <= 4'd7;
                                cur_last <= tx_last;
                            end
                        end else begin
                            usb_dp  <= 1'b0;
                            usb_dn  <= 1'b0;
                            eop_cnt <= 1'b0;
                            state   <= EOP_SE0;
                        end
                    end
                end
                EOP_SE0: begin
                    if (tick) begin
                        if (!eop_cnt) begin
                            eop_cnt <= 1'b1;
                        end else begin
                            usb_dp <= 1'b1;
                            usb_dn <= 1'b0;
                            state  <= EOP_J;
                        end
                    end
                end
                EOP_J: begin
                    if (tick) begin
                        usb_oe  <= 1'b0;
                        usb_dp  <= 1'b1;
                        usb_dn  <= 1'b0;
                        tx_done <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_usb_tx.sv
// Bench for usb_tx: table of packets plus hand-written reset and
// back-to-back sequences; line symbols are scoreboarded against a
// bit-level encoder model.
module tb_usb_tx;

    logic       clock48 = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_last = 1'b0;
    logic       tx_ready, usb_dp, usb_dn, usb_oe, tx_done, tx_underflow;
    logic [2:0] state_dbg;

    int errors = 0;
    int checks = 0;

    logic [1:0] exp_q[$];
    int         len_q[$];
    bit         mon_check = 1'b1;

    int oe_cnt = 0, low_cnt = 0, last_gap = 0, last_len = 0;
    int n_ready = 0, n_done = 0, n_uf = 0, n_rises = 0;
    int first_ready_at = 0, uf_at = 0;

    usb_tx #(.CLOCKS_PER_BIT(4)) dut (
        .clock48(clock48), .reset_n(reset_n),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last),
        .tx_ready(tx_ready), .usb_dp(usb_dp), .usb_dn(usb_dn),
        .usb_oe(usb_oe), .tx_done(tx_done), .tx_underflow(tx_underflow),
        .state_dbg(state_dbg)
    );

    // clock / reset block
    always #5 clock48 = ~clock48;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // monitor: line symbols, pulse counts and oe timing
    always @(negedge clock48) begin
        if (usb_dp || usb_dn) check("dn_is_not_dp", usb_dn, !usb_dp);
        if (tx_ready) check("ready_needs_valid", tx_valid, 1);
        if (!reset_n) begin
            oe_cnt  = 0;
            low_cnt = 0;
        end else if (usb_oe) begin
            if (oe_cnt == 0) begin
                last_gap = low_cnt;
                n_rises++;
            end
            oe_cnt++;
            low_cnt = 0;
            if (tx_ready) begin
                n_ready++;
                if (first_ready_at == 0) first_ready_at = oe_cnt;
            end
            if (tx_underflow) begin
                n_uf++;
                uf_at = oe_cnt;
            end
            if (mon_check && (oe_cnt % 4 == 2)) begin
                if (exp_q.size() == 0) check("extra_symbol", 1, 0);
                else                   check("line_symbol", {usb_dp, usb_dn}, exp_q.pop_front());
            end
        end else begin
            if (oe_cnt != 0) begin
                last_len = oe_cnt;
                if (mon_check) begin
                    if (len_q.size() == 0) check("unexpected_packet", 1, 0);
                    else                   check("oe_cycles", oe_cnt, len_q.pop_front());
                end
            end
            oe_cnt = 0;
            low_cnt++;
            check("idle_lines", {usb_dp, usb_dn}, 2'b10);
        end
        if (tx_done) n_done++;
    end

    // encoder model: pushes expected {dp,dn} symbols and oe length
    task automatic model_push(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                              input int n, input bit abort);
        logic [7:0] bs[3];
        logic       lvl, d;
        int         ones, nsym;
        bs[0] = b0; bs[1] = b1; bs[2] = b2;
        nsym = 0;
        for (int k = 0; k < 8; k++) begin
            d = (k % 2 == 1) && (k != 7);
            exp_q.push_back({d, ~d});
            nsym++;
        end
        lvl  = 1'b0;
        ones = 1;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < 8; j++) begin
                if (bs[i][j]) ones++;
                else begin lvl = ~lvl; ones = 0; end
                exp_q.push_back({lvl, ~lvl});
                nsym++;
                if (ones == 6 && !(abort && i == n - 1 && j == 7)) begin
                    lvl  = ~lvl;
                    ones = 0;
                    exp_q.push_back({lvl, ~lvl});
                    nsym++;
                end
            end
        end
        exp_q.push_back(2'b00);
        exp_q.push_back(2'b00);
        exp_q.push_back(2'b10);
        len_q.push_back((nsym + 3) * 4);
    endtask

    // driver: offers bytes, then waits for tx_done (returns at that negedge)
    task automatic send_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                               input int n, input bit abort);
        logic [7:0] bs[3];
        int  idx, cyc;
        bit  hit;
        bs[0] = b0; bs[1] = b1; bs[2] = b2;
        idx = 0; cyc = 0;
        tx_data  = bs[0];
        tx_last  = (n == 1) && !abort;
        tx_valid = 1'b1;
        while (idx < n && cyc < 3000) begin
            @(negedge clock48);
            cyc++;
            hit = tx_ready;
            @(posedge clock48);
            #1;
            if (hit) begin
                idx++;
                if (idx < n) begin
                    tx_data = bs[idx];
                    tx_last = (idx == n - 1) && !abort;
                end else begin
                    tx_valid = 1'b0;
                    tx_last  = 1'b0;
                end
            end
        end
        if (idx < n) check("byte_accept_timeout", idx, n);
        tx_valid = 1'b0;
        cyc = 0;
        do begin
            @(negedge clock48);
            cyc++;
        end while (!tx_done && cyc < 3000);
        check("done_seen", tx_done, 1);
    endtask

    task automatic clear_counts();
        n_ready = 0; n_done = 0; n_uf = 0;
        first_ready_at = 0; uf_at = 0;
    endtask

    typedef struct {
        logic [7:0] b0, b1, b2;
        int         n;
        bit         abort;
        int         exp_oe;   // -1: length only from the model
    } vec_t;

    vec_t vecs[6];

    initial begin
        int rises_after_reset;

        vecs[0] = '{8'hD2, 8'h00, 8'h00, 1, 1'b0, 76};
        vecs[1] = '{8'hC3, 8'hFF, 8'h00, 2, 1'b0, 112};
        vecs[2] = '{8'hFC, 8'h00, 8'h00, 1, 1'b0, 80};
        vecs[3] = '{8'h4B, 8'h00, 8'h00, 1, 1'b1, 76};
        vecs[4] = '{8'h00, 8'h7F, 8'hA5, 3, 1'b0, -1};
        vecs[5] = '{8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                    8'($urandom_range(0, 255)), $urandom_range(1, 3), 1'b0, -1};

        // reset state
        repeat (3) @(negedge clock48);
        check("rst_oe", usb_oe, 0);
        check("rst_dp", usb_dp, 1);
        check("rst_dn", usb_dn, 0);
        check("rst_ready", tx_ready, 0);
        check("rst_done", tx_done, 0);
        check("rst_underflow", tx_underflow, 0);
        check("rst_state", state_dbg, 0);
        reset_n = 1'b1;
        repeat (3) @(negedge clock48);

        // table-driven packets
        for (int i = 0; i < 6; i++) begin
            clear_counts();
            model_push(vecs[i].b0, vecs[i].b1, vecs[i].b2, vecs[i].n, vecs[i].abort);
            send_packet(vecs[i].b0, vecs[i].b1, vecs[i].b2, vecs[i].n, vecs[i].abort);
            #1;
            if (vecs[i].exp_oe > 0) check("table_oe_cycles", last_len, vecs[i].exp_oe);
            check("ready_count", n_ready, vecs[i].n);
            check("done_count", n_done, 1);
            check("first_ready_at_sync_end", first_ready_at, 32);
            check("underflow_count", n_uf, vecs[i].abort ? 1 : 0);
            if (vecs[i].abort) check("underflow_at_bit7_end", uf_at, 32 + vecs[i].n * 32);
            check("symbols_left", exp_q.size(), 0);
            repeat (3) @(negedge clock48);
        end

        // reset during data bit 3 of 0x69
        mon_check = 1'b0;
        tx_data = 8'h69; tx_last = 1'b1; tx_valid = 1'b1;
        for (int c = 0; c < 20 && !usb_oe; c++) @(negedge clock48);
        check("reset_test_started", usb_oe, 1);
        repeat (45) @(negedge clock48);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_oe", usb_oe, 0);
        check("async_rst_dp", usb_dp, 1);
        check("async_rst_dn", usb_dn, 0);
        tx_valid = 1'b0; tx_last = 1'b0;
        repeat (3) @(negedge clock48);
        reset_n = 1'b1;
        mon_check = 1'b1;
        #1;
        rises_after_reset = n_rises;
        repeat (20) @(negedge clock48);
        #1;
        check("stay_idle_oe", usb_oe, 0);
        check("stay_idle_state", state_dbg, 0);
        check("stay_idle_no_rise", n_rises, rises_after_reset);

        // back-to-back: next packet offered in the tx_done cycle
        clear_counts();
        model_push(8'h5A, 8'h00, 8'h00, 1, 1'b0);
        model_push(8'h96, 8'h00, 8'h00, 1, 1'b0);
        send_packet(8'h5A, 8'h00, 8'h00, 1, 1'b0);
        send_packet(8'h96, 8'h00, 8'h00, 1, 1'b0);
        #1;
        check("b2b_gap_cycles", last_gap, 2);
        check("b2b_done_count", n_done, 2);
        check("b2b_ready_count", n_ready, 2);
        check("b2b_symbols_left", exp_q.size(), 0);
        check("b2b_lengths_left", len_q.size(), 0);

        repeat (4) @(negedge clock48);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // watchdog
    initial begin
        #500000;
        errors++;
        checks++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
